load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit.sv | 76 +++++++
 tb/tb_load_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: MEM-stage load FSM with byte/halfword extraction, sign/zero extension and ack timeout.
// Define LOAD_ALIGN_CHECK_EN to reject misaligned LW/LH/LHU with an ld_err pulse instead of issuing them.
module load_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [2:0]  ld_op,
  input  logic [31:0] ld_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [31:0] ld_data,
  output logic        ld_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_data, w_ext;
  logic [7:0]  r_cnt, w_byte;
  logic [15:0] w_half;
  logic        r_err, w_misalign, w_accept, w_timeout;
`ifdef LOAD_ALIGN_CHECK_EN
  assign w_misalign = (ld_op == 3'd1 || ld_op == 3'd2) ? ld_addr[0] :
                      (ld_op == 3'd3 || ld_op == 3'd4) ? 1'b0 : |ld_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif
  assign w_accept  = r_state == IDLE && ld_valid && !w_misalign;
  // the deadline cycle itself still honours an ack
  assign w_timeout = r_state == WAIT && !mem_ack && r_cnt == 8'(MAX_WAIT);
  assign w_byte    = mem_rdata[8*r_addr[1:0] +: 8];
  assign w_half    = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  always_comb begin
    w_ext = r_op == 3'd1 ? {{16{w_half[15]}}, w_half} :
            r_op == 3'd2 ? {16'b0, w_half} :
            r_op == 3'd3 ? {{24{w_byte[7]}}, w_byte} :
            r_op == 3'd4 ? {24'b0, w_byte} : mem_rdata;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_accept ? WAIT : IDLE;
    else if (r_state == WAIT) w_next = mem_ack ? DONE : w_timeout ? IDLE : WAIT;
    else w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= 3'd0;
      r_addr  <= 32'd0;
      r_cnt   <= 8'd0;
      r_data  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == IDLE && ld_valid && w_misalign) || w_timeout;
      if (w_accept) begin
        r_op   <= ld_op;
        r_addr <= ld_addr;
        r_cnt  <= 8'd0;
      end
      if (r_state == WAIT && !mem_ack) r_cnt <= r_cnt + 8'd1;
      if (r_state == WAIT && mem_ack) r_data <= w_ext;
    end
  end
  assign mem_req  = r_state == WAIT;
  assign mem_addr = {r_addr[31:2], 2'b00};
  assign ld_busy  = !rst && (w_accept || r_state == WAIT);
  assign ld_done  = r_state == DONE;
  assign ld_data  = r_data;
  assign ld_err   = r_err;
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed load sequences checked every cycle against a transaction-level model.
module tb_load_unit;
  localparam int MW = 15;
  logic        clk = 1'b0, rst = 1'b1, ld_valid = 1'b0, mem_ack = 1'b0;
  logic [2:0]  ld_op = 3'd0;
  logic [31:0] ld_addr = 32'd0, mem_rdata = 32'd0;
  logic        mem_req, ld_busy, ld_done, ld_err;
  logic [31:0] mem_addr, ld_data;
  int checks = 0, failures = 0;

  load_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_op(ld_op), .ld_addr(ld_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_data(ld_data), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
    int unsigned b, h;
    b = (rd >> (8 * (a % 4))) % 256;
    h = (a % 4 >= 2) ? rd / 65536 : rd % 65536;
    case (op)
      3'd1: return h >= 32768 ? h + 32'hFFFF_0000 : h;
      3'd2: return h;
      3'd3: return b >= 128 ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      default: return rd;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] op, input logic [31:0] a);
`ifdef LOAD_ALIGN_CHECK_EN
    if (op == 3'd1 || op == 3'd2) return a % 2 != 0;
    if (op == 3'd3 || op == 3'd4) return 1'b0;
    return a % 4 != 0;
`else
    return 1'b0;
`endif
  endfunction

  // model: an outstanding access, how many ack-less cycles it has waited, and one-cycle result flags
  bit          m_out, m_done, m_err, was_idle;
  int          m_waited;
  logic [2:0]  m_op;
  logic [31:0] m_addr, m_data;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out = 0; m_done = 0; m_err = 0; m_waited = 0; m_addr = 0; m_data = 0; m_op = 0;
    end else begin
      was_idle = !m_out && !m_done;
      m_done = 0;
      m_err = 0;
      if (m_out) begin
        if (mem_ack) begin
          m_data = ref_ext(m_op, m_addr, mem_rdata);
          m_done = 1;
          m_out = 0;
        end else if (m_waited == MW) begin
          m_out = 0;
          m_err = 1;
        end else m_waited++;
      end else if (was_idle && ld_valid) begin
        if (ref_mis(ld_op, ld_addr)) m_err = 1;
        else begin
          m_out = 1; m_waited = 0; m_op = ld_op; m_addr = ld_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("mem_req", {31'b0, mem_req}, {31'b0, m_out});
      if (m_out) chk("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
      chk("ld_busy", {31'b0, ld_busy},
          {31'b0, m_out || (!m_done && ld_valid && !ref_mis(ld_op, ld_addr))});
      chk("ld_done", {31'b0, ld_done}, {31'b0, m_done});
      chk("ld_err", {31'b0, ld_err}, {31'b0, m_err});
      chk("ld_data", ld_data, m_data);
    end
  end

  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic ack, input logic [31:0] rd);
    ld_valid = v; ld_op = op; ld_addr = a; mem_ack = ack; mem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd, input int dly);
    step(1, op, a, 0, 0);
    repeat (dly) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, rd);
    chk("done_pulse", {31'b0, ld_done}, 32'd1);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_done_err", {30'b0, ld_done, ld_err}, 32'd0);
    rst = 0;
    step(0, 0, 0, 0, 0);
    step(1, 3'd3, 32'h103, 0, 0);
    chk("lb_mem_addr", mem_addr, 32'h100);
    chk("lb_mem_req", {31'b0, mem_req}, 32'd1);
    step(0, 0, 0, 1, 32'h80FF_0000);
    chk("lb_done", {31'b0, ld_done}, 32'd1);
    chk("lb_data", ld_data, 32'hFFFF_FF80);
    step(0, 0, 0, 0, 0);
    chk("lb_done_once", {31'b0, ld_done}, 32'd0);
    ld(3'd2, 32'h202, 32'h9ABC_1234, 0);
    chk("lhu_data", ld_data, 32'h0000_9ABC);
    ld(3'd1, 32'h202, 32'h9ABC_1234, 1);
    chk("lh_data", ld_data, 32'hFFFF_9ABC);
    ld(3'd4, 32'h101, 32'h1234_5678, 2);
    chk("lbu_data", ld_data, 32'h0000_0056);
    ld(3'd1, 32'h200, 32'h1234_7FFE, 0);
    chk("lh_pos", ld_data, 32'h0000_7FFE);
    ld(3'd6, 32'h44, 32'hDEAD_BEEF, 0);
    chk("lw_op6", ld_data, 32'hDEAD_BEEF);
    step(1, 3'd0, 32'h40, 0, 0);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step(0, 0, 0, 0, 0);
    end
    chk("to_wait_cycles", n, MW + 1);
    chk("to_err", {31'b0, ld_err}, 32'd1);
    chk("to_req_low", {31'b0, mem_req}, 32'd0);
    chk("to_data_kept", ld_data, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0);
    chk("to_err_once", {31'b0, ld_err}, 32'd0);
    ld(3'd0, 32'h40, 32'hCAFE_F00D, 3);
    chk("lw_ack3", ld_data, 32'hCAFE_F00D);
    step(1, 3'd0, 32'h48, 0, 0);
    repeat (MW) step(0, 0, 0, 0, 0);
    chk("edge_req", {31'b0, mem_req}, 32'd1);
    step(0, 0, 0, 1, 32'h1122_3344);
    chk("edge_done", {31'b0, ld_done}, 32'd1);
    chk("edge_no_err", {31'b0, ld_err}, 32'd0);
    chk("edge_data", ld_data, 32'h1122_3344);
    step(0, 0, 0, 1, 32'hFFFF_FFFF);
    chk("edge_err_after", {31'b0, ld_err}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("idle_ack_ignored", {31'b0, ld_done}, 32'd0);
    step(1, 3'd4, 32'h103, 0, 0);
    step(1, 3'd0, 32'h200, 1, 32'hA500_0000);
    step(1, 3'd0, 32'h200, 0, 0);
    chk("valid_in_done_ignored", {31'b0, mem_req}, 32'd0);
    chk("lbu3_data", ld_data, 32'h0000_00A5);
    step(0, 0, 0, 0, 0);
    step(1, 3'd0, 32'h80, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1;
    #1;
    chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_busy", {31'b0, ld_busy}, 32'd0);
    chk("mid_rst_data", ld_data, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    mem_ack = 1;
    mem_rdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (3) begin
      step(0, 0, 0, 1, 32'h5555_5555);
      chk("post_rst_no_done", {31'b0, ld_done}, 32'd0);
    end
    step(0, 0, 0, 0, 0);
`ifdef LOAD_ALIGN_CHECK_EN
    ld_valid = 1; ld_op = 3'd0; ld_addr = 32'h41;
    #1;
    chk("mis_busy", {31'b0, ld_busy}, 32'd0);
    @(posedge clk);
    #1;
    ld_valid = 0;
    #1;
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_err", {31'b0, ld_err}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("mis_err_once", {31'b0, ld_err}, 32'd0);
`else
    step(1, 3'd0, 32'h41, 0, 0);
    chk("unal_mem_addr", mem_addr, 32'h40);
    step(0, 0, 0, 1, 32'h8765_4321);
    chk("unal_data", ld_data, 32'h8765_4321);
    step(0, 0, 0, 0, 0);
    ld(3'd2, 32'h203, 32'h9ABC_1234, 0);
    chk("unal_lhu", ld_data, 32'h0000_9ABC);
`endif
    step(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
